// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, execute-stage state encoding and a
// small classification helper used by both the decoder and the execute stage.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter: holds the operand, the remaining shift
// count and the direction/arithmetic control for the op in flight.
import alu_pkg::*;

module alu_shift_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               start,
    input  logic [XLEN-1:0]    start_value,
    input  logic [SHAMT_W-1:0] start_amount,
    input  logic               start_left,
    input  logic               start_arith,
    input  logic               step,
    output logic               done,
    output logic [XLEN-1:0]    value_next
);

    logic [XLEN-1:0]    operand_reg;
    logic [SHAMT_W-1:0] count_reg;
    logic               left_reg;
    logic               arith_reg;

    // One-bit shift of the held operand; SRA refills the MSB with itself.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign value_next[gi] = left_reg ? 1'b0 : operand_reg[gi+1];
            end else if (gi == XLEN-1) begin : g_msb
                assign value_next[gi] = left_reg ? operand_reg[gi-1]
                                                 : (arith_reg & operand_reg[gi]);
            end else begin : g_mid
                assign value_next[gi] = left_reg ? operand_reg[gi-1] : operand_reg[gi+1];
            end
        end
    endgenerate

    // The step taken while the count reads 1 is the last one.
    assign done = step && (count_reg == SHAMT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            operand_reg <= '0;
            count_reg   <= '0;
            left_reg    <= 1'b0;
            arith_reg   <= 1'b0;
        end else if (start) begin
            operand_reg <= start_value;
            count_reg   <= start_amount;
            left_reg    <= start_left;
            arith_reg   <= start_arith;
        end else if (step && count_reg != '0) begin
            operand_reg <= value_next;
            count_reg   <= count_reg - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle combinational ops, multi-cycle shifts via
// alu_shift_unit, and a valid/ready hold register for the result.
import alu_pkg::*;

module alu_exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    alu_state_e      state_reg, state_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [4:0]      rd_out_reg, rd_out_next;
    logic [4:0]      rd_pend_reg, rd_pend_next;

    logic               accept;
    logic               op_is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic               start_shift;
    logic               shift_step;
    logic               shift_done;
    logic [XLEN-1:0]    shift_value;
    logic [XLEN-1:0]    alu_comb;

    assign in_ready    = !rst && (state_reg == ST_IDLE);
    assign accept      = in_valid && in_ready && !flush;
    assign op_is_shift = is_shift_op(alu_op);
    assign shamt       = op_b[SHAMT_W-1:0];
    assign start_shift = accept && op_is_shift && (shamt != '0);
    assign shift_step  = (state_reg == ST_SHIFT) && !flush;

    assign out_valid = (state_reg == ST_HOLD);
    assign busy      = (state_reg == ST_SHIFT);
    assign result    = result_reg;
    assign rd_out    = rd_out_reg;

    // Shift codes pass op_a through; that value is only used when the amount is 0.
    always_comb begin
        alu_comb = '0;
        case (alu_op)
            ALU_ADD:  alu_comb = op_a + op_b;
            ALU_SUB:  alu_comb = op_a - op_b;
            ALU_SLT:  alu_comb = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_comb = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_comb = op_a ^ op_b;
            ALU_OR:   alu_comb = op_a | op_b;
            ALU_AND:  alu_comb = op_a & op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_comb = op_a;
            default:  alu_comb = '0;
        endcase
    end

    alu_shift_unit #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .start        (start_shift),
        .start_value  (op_a),
        .start_amount (shamt),
        .start_left   (alu_op == ALU_SLL),
        .start_arith  (alu_op == ALU_SRA),
        .step         (shift_step),
        .done         (shift_done),
        .value_next   (shift_value)
    );

    // Flush overrides everything; the tag of a shift waits in rd_pend until done.
    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        rd_out_next  = rd_out_reg;
        rd_pend_next = rd_pend_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_shift) begin
                        state_next   = ST_SHIFT;
                        rd_pend_next = rd_in;
                    end else if (accept) begin
                        state_next  = ST_HOLD;
                        result_next = alu_comb;
                        rd_out_next = rd_in;
                    end
                end
                ST_SHIFT: begin
                    if (shift_done) begin
                        state_next  = ST_HOLD;
                        result_next = shift_value;
                        rd_out_next = rd_pend_reg;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            result_reg  <= '0;
            rd_out_reg  <= '0;
            rd_pend_reg <= '0;
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            rd_out_reg  <= rd_out_next;
            rd_pend_reg <= rd_pend_next;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: hand-computed vectors, latency, hold,
// flush and reset behaviour.
import alu_pkg::*;

module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one op with out_ready high, scramble the inputs after accept, then
    // check latency, busy cycles, result, tag and the drain bubble.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int busy_cnt;
        out_ready = 1'b1;
        alu_op = op; op_a = a; op_b = b; rd_in = rd; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_op = 4'b1111; op_a = 32'h5A5A_5A5A; op_b = 32'h0000_0003; rd_in = 5'd31;
        cyc = 1;
        busy_cnt = 0;
        while (!out_valid && cyc < 100) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        $display("op %s: latency=%0d busy=%0d result=%h rd=%0d", tag, cyc, busy_cnt, result, rd_out);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_rd"}, 32'(rd_out), 32'(rd));
        check({tag, "_inready_hold"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen_valid;
        rst = 1'b1; in_valid = 1'b0; alu_op = '0; op_a = '0; op_b = '0;
        rd_in = '0; flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_inready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_inready", 32'(in_ready), 32'd1);

        run_op("add_wrap", ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd5,  32'h0000_0000, 1);
        run_op("slt",      ALU_SLT,  32'hFFFF_FFFE, 32'h0000_0001, 5'd6,  32'h0000_0001, 1);
        run_op("sltu",     ALU_SLTU, 32'hFFFF_FFFE, 32'h0000_0001, 5'd7,  32'h0000_0000, 1);
        run_op("sub",      ALU_SUB,  32'h0000_0005, 32'h0000_0007, 5'd8,  32'hFFFF_FFFE, 1);
        run_op("xor",      ALU_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd9,  32'hFF00_FF00, 1);
        run_op("or",       ALU_OR,   32'h1234_0000, 32'h0000_5678, 5'd10, 32'h1234_5678, 1);
        run_op("and",      ALU_AND,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd11, 32'h0F0F_0000, 1);
        run_op("bad_code", 4'b1010,  32'h1234_5678, 32'h8765_4321, 5'd12, 32'h0000_0000, 1);
        run_op("srl4",     ALU_SRL,  32'h0000_00F0, 32'h0000_0004, 5'd13, 32'h0000_000F, 5);
        run_op("sll_hi",   ALU_SLL,  32'h0000_0001, 32'h0000_0023, 5'd14, 32'h0000_0008, 4);
        run_op("sra31",    ALU_SRA,  32'h8000_0000, 32'h0000_001F, 5'd15, 32'hFFFF_FFFF, 32);

        // SLL by 0 with downstream stalled for five cycles.
        out_ready = 1'b0;
        alu_op = ALU_SLL; op_a = 32'h0000_0001; op_b = 32'h0000_0020; rd_in = 5'd16; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("sll0_latency_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            $display("stall cycle %0d: out_valid=%0d result=%h rd=%0d in_ready=%0d",
                     i, out_valid, result, rd_out, in_ready);
            check("sll0_hold_valid", 32'(out_valid), 32'd1);
            check("sll0_hold_result", result, 32'h0000_0001);
            check("sll0_hold_rd", 32'(rd_out), 32'd16);
            check("sll0_hold_inready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("sll0_drained", 32'(out_valid), 32'd0);

        // Flush in the fourth shift cycle of an SRL by 10, with a new op offered.
        alu_op = ALU_SRL; op_a = 32'hFFFF_0000; op_b = 32'd10; rd_in = 5'd17; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("flush_busy_before", 32'(busy), 32'd1);
        flush = 1'b1; in_valid = 1'b1; alu_op = ALU_ADD; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd18;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        $display("after flush: out_valid=%0d in_ready=%0d busy=%0d", out_valid, in_ready, busy);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_inready", 32'(in_ready), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        check("flush_no_output", 32'(seen_valid), 32'd0);

        // Reset while holding a result.
        out_ready = 1'b0;
        alu_op = ALU_ADD; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("hold_before_rst_valid", 32'(out_valid), 32'd1);
        check("hold_before_rst_result", result, 32'd7);
        rst = 1'b1;
        tick();
        $display("after reset in hold: out_valid=%0d result=%h rd=%0d in_ready=%0d",
                 out_valid, result, rd_out, in_ready);
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        check("rst_hold_result", result, 32'd0);
        check("rst_hold_rd", 32'(rd_out), 32'd0);
        check("rst_hold_inready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_hold_idle", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
